// File: rtl/ctrl_pipe_e.sv
// E-stage control unit: registers the D-stage instruction with its decoded control
// word, and tracks how long the multi-cycle mult/div unit stays occupied.
module ctrl_pipe_e #(
    parameter int ALUOP_W     = 4,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr_D,
    input  logic               stall,
    input  logic               flush,
    output logic [31:0]        instr_E,
    output logic               regdst_E,
    output logic               alusrc_E,
    output logic [ALUOP_W-1:0] aluop,
    output logic               regwrite_E,
    output logic               memtoreg_E,
    output logic               lb_memtoreg_E,
    output logic               memwrite_E,
    output logic               link_E,
    output logic               movz_E,
    output logic               hilo_rd_E,
    output logic               md_start,
    output logic [1:0]         md_op,
    output logic               md_busy,
    output logic               md_hazard_D
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SW     = 6'b101011;

    typedef struct packed {
        logic               regdst;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               regwrite;
        logic               memtoreg;
        logic               lb_memtoreg;
        logic               memwrite;
        logic               link;
        logic               movz;
        logic               hilo_rd;
        logic               md_start;
        logic [1:0]         md_op;
    } ctrl_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       is_md_D;
    logic       is_hilo_D;
    logic       capture;
    ctrl_t      dec;
    ctrl_t      ctrl_q;
    logic [CNT_W-1:0] cnt;

    assign opcode  = instr_D[31:26];
    assign funct   = instr_D[5:0];
    assign rt      = instr_D[20:16];
    assign capture = !stall && !flush;

    // mult/multu/div/divu are funct 0110xx; mfhi/mthi/mflo/mtlo are 0100xx.
    assign is_md_D   = (opcode == OP_RTYPE) && (funct[5:2] == 4'b0110);
    assign is_hilo_D = (opcode == OP_RTYPE) && ((funct[5:2] == 4'b0110) || (funct[5:2] == 4'b0100));

    always_comb begin
        // NOTE: default every field first so no path leaves a field unassigned (no latches).
        dec = '0;
        unique case (opcode)
            OP_RTYPE: begin
                dec.regdst   = 1'b1;
                dec.regwrite = 1'b1;
                case (funct)
                    6'b100000, 6'b100001: dec.aluop = ALUOP_W'(0);
                    6'b100010, 6'b100011: dec.aluop = ALUOP_W'(1);
                    6'b100100: dec.aluop = ALUOP_W'(2);
                    6'b100101: dec.aluop = ALUOP_W'(3);
                    6'b100110: dec.aluop = ALUOP_W'(6);
                    6'b100111: dec.aluop = ALUOP_W'(7);
                    6'b000000: dec.aluop = ALUOP_W'(8);
                    6'b000100: dec.aluop = ALUOP_W'(9);
                    6'b000010: dec.aluop = ALUOP_W'(10);
                    6'b000110: dec.aluop = ALUOP_W'(11);
                    6'b101010: dec.aluop = ALUOP_W'(12);
                    6'b000011: dec.aluop = ALUOP_W'(14);
                    6'b001010: begin dec.aluop = ALUOP_W'(15); dec.movz = 1'b1; end
                    6'b001001: dec.link = 1'b1;
                    6'b010000, 6'b010010: dec.hilo_rd = 1'b1;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        dec.regdst   = 1'b0;
                        dec.regwrite = 1'b0;
                        dec.md_start = 1'b1;
                        dec.md_op    = funct[1:0];
                    end
                    default: dec = '0;
                endcase
            end
            OP_ADDI:  begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = ALUOP_W'(0);  end
            OP_SLTI:  begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = ALUOP_W'(12); end
            OP_SLTIU: begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = ALUOP_W'(13); end
            OP_ANDI:  begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = ALUOP_W'(2);  end
            OP_ORI:   begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = ALUOP_W'(3);  end
            OP_XORI:  begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = ALUOP_W'(6);  end
            OP_LUI:   begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = ALUOP_W'(5);  end
            OP_LW:    begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.memtoreg = 1'b1;    end
            OP_LB:    begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.lb_memtoreg = 1'b1; end
            OP_SW, OP_SB: begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; end
            OP_JAL:   begin dec.link = 1'b1; dec.regwrite = 1'b1; end
            OP_REGIMM: begin
                if (rt == 5'b10001 || rt == 5'b10000) begin
                    dec.link     = 1'b1;
                    dec.regwrite = 1'b1;
                end
            end
            default: dec = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_E <= '0;
            ctrl_q  <= '0;
            cnt     <= '0;
        end else begin
            if (capture) begin
                instr_E <= instr_D;
                ctrl_q  <= dec;
            end else begin
                instr_E <= '0;
                ctrl_q  <= '0;
            end
            // A newly captured mult/div reloads even if the unit is still counting.
            if (capture && is_md_D)
                cnt <= funct[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    assign regdst_E      = ctrl_q.regdst;
    assign alusrc_E      = ctrl_q.alusrc;
    assign aluop         = ctrl_q.aluop;
    assign regwrite_E    = ctrl_q.regwrite;
    assign memtoreg_E    = ctrl_q.memtoreg;
    assign lb_memtoreg_E = ctrl_q.lb_memtoreg;
    assign memwrite_E    = ctrl_q.memwrite;
    assign link_E        = ctrl_q.link;
    assign movz_E        = ctrl_q.movz;
    assign hilo_rd_E     = ctrl_q.hilo_rd;
    assign md_start      = ctrl_q.md_start;
    assign md_op         = ctrl_q.md_op;
    assign md_busy       = (cnt != '0);
    assign md_hazard_D   = (md_busy || md_start) && is_hilo_D;

endmodule

// File: tb/tb_ctrl_pipe_e.sv
// Scoreboard bench for ctrl_pipe_e: a table-driven reference model predicts each
// cycle's outputs; a monitor compares them against the DUT one cycle at a time.
module tb_ctrl_pipe_e;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [31:0] instr_D;
    logic [31:0] instr_E;
    logic        regdst_E, alusrc_E, regwrite_E, memtoreg_E, lb_memtoreg_E, memwrite_E;
    logic        link_E, movz_E, hilo_rd_E, md_start, md_busy, md_hazard_D;
    logic [3:0]  aluop;
    logic [1:0]  md_op;

    always #5 clk = ~clk;

    ctrl_pipe_e #(.ALUOP_W(4), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .instr_D(instr_D), .stall(stall), .flush(flush),
        .instr_E(instr_E), .regdst_E(regdst_E), .alusrc_E(alusrc_E), .aluop(aluop),
        .regwrite_E(regwrite_E), .memtoreg_E(memtoreg_E), .lb_memtoreg_E(lb_memtoreg_E),
        .memwrite_E(memwrite_E), .link_E(link_E), .movz_E(movz_E), .hilo_rd_E(hilo_rd_E),
        .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_hazard_D(md_hazard_D)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        regdst, alusrc;
        logic [3:0]  aluop;
        logic        regwrite, memtoreg, lb, memwrite, link, movz, hilo_rd, md_start;
        logic [1:0]  md_op;
        logic        md_busy, hazard;
    } obs_t;

    obs_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         busy_end = 0;
    logic [3:0] r_alu [logic [5:0]];
    logic [3:0] i_alu [logic [5:0]];
    logic [5:0] i_ops [12] = '{6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
                               6'd35, 6'd32, 6'd43, 6'd40, 6'd3};

    task automatic check(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic hilo_class(logic [31:0] ins);
        return (ins[31:26] == 6'd0) &&
               (ins[5:0] inside {6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27});
    endfunction

    function automatic obs_t ref_decode(logic [31:0] ins);
        obs_t       e;
        logic [5:0] op, fn;
        logic [4:0] rt;
        e  = '0;
        op = ins[31:26];
        fn = ins[5:0];
        rt = ins[20:16];
        e.instr = ins;
        if (op == 6'd0) begin
            if (r_alu.exists(fn)) begin
                e.aluop = r_alu[fn]; e.regdst = 1'b1; e.regwrite = 1'b1;
                e.link = (fn == 6'd9); e.movz = (fn == 6'd10);
            end else if (fn == 6'd16 || fn == 6'd18) begin
                e.regdst = 1'b1; e.regwrite = 1'b1; e.hilo_rd = 1'b1;
            end else if (fn >= 6'd24 && fn <= 6'd27) begin
                e.md_start = 1'b1; e.md_op = 2'(fn - 6'd24);
            end
        end else if (i_alu.exists(op)) begin
            e.alusrc = 1'b1; e.regwrite = 1'b1; e.aluop = i_alu[op];
        end else if (op == 6'd35) begin
            e.alusrc = 1'b1; e.regwrite = 1'b1; e.memtoreg = 1'b1;
        end else if (op == 6'd32) begin
            e.alusrc = 1'b1; e.regwrite = 1'b1; e.lb = 1'b1;
        end else if (op == 6'd43 || op == 6'd40) begin
            e.alusrc = 1'b1; e.memwrite = 1'b1;
        end else if (op == 6'd3 || (op == 6'd1 && (rt == 5'd16 || rt == 5'd17))) begin
            e.link = 1'b1; e.regwrite = 1'b1;
        end
        return e;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(logic [31:0] ins, logic st, logic fl, logic rs);
        obs_t e;
        @(negedge clk);
        instr_D = ins; stall = st; flush = fl; reset = rs;
        cyc++;
        e = '0;
        if (rs) begin
            busy_end = cyc;
        end else if (!st && !fl) begin
            e = ref_decode(ins);
            if (e.md_start) busy_end = cyc + (e.md_op[1] ? DIV_N : MULT_N);
        end
        e.md_busy = (cyc < busy_end);
        e.hazard  = (e.md_busy || e.md_start) && hilo_class(ins);
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 7))
            0, 1: r[31:26] = 6'd0;
            2, 3: begin
                r[31:26] = 6'd0;
                r[5:0]   = 6'(16 + $urandom_range(0, 3) + 8 * $urandom_range(0, 1));
            end
            4, 5: r[31:26] = i_ops[$urandom_range(0, 11)];
            6: begin
                r[31:26] = 6'd1;
                r[20:16] = 5'(16 + $urandom_range(0, 1));
            end
            default: ;
        endcase
        return r;
    endfunction

    initial begin : monitor
        obs_t e, a;
        int   n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {instr_E, regdst_E, alusrc_E, aluop, regwrite_E, memtoreg_E, lb_memtoreg_E,
                     memwrite_E, link_E, movz_E, hilo_rd_E, md_start, md_op, md_busy, md_hazard_D};
                if (!e.md_start) begin
                    a.md_op = 2'd0;
                    e.md_op = 2'd0;
                end
                n++;
                check($sformatf("cycle%0d", n), a, e);
            end
        end
    end

    initial begin : stimulus
        r_alu[6'd32] = 4'd0;  r_alu[6'd33] = 4'd0;  r_alu[6'd34] = 4'd1;  r_alu[6'd35] = 4'd1;
        r_alu[6'd36] = 4'd2;  r_alu[6'd37] = 4'd3;  r_alu[6'd38] = 4'd6;  r_alu[6'd39] = 4'd7;
        r_alu[6'd0]  = 4'd8;  r_alu[6'd4]  = 4'd9;  r_alu[6'd2]  = 4'd10; r_alu[6'd6]  = 4'd11;
        r_alu[6'd42] = 4'd12; r_alu[6'd3]  = 4'd14; r_alu[6'd10] = 4'd15; r_alu[6'd9]  = 4'd0;
        i_alu[6'd8]  = 4'd0;  i_alu[6'd10] = 4'd12; i_alu[6'd11] = 4'd13; i_alu[6'd12] = 4'd2;
        i_alu[6'd13] = 4'd3;  i_alu[6'd14] = 4'd6;  i_alu[6'd15] = 4'd5;

        reset = 1'b1; stall = 1'b0; flush = 1'b0; instr_D = 32'h0;

        step(32'h00221821, 0, 0, 1);
        step(32'h00221821, 0, 0, 1);
        step(32'h00221821, 0, 0, 0);   // addu
        step(32'h8C430004, 1, 0, 0);   // lw stalled: bubble
        step(32'h8C430004, 0, 0, 0);   // lw
        step(32'h00430018, 0, 0, 0);   // mult
        repeat (5) step(32'h00002012, 1, 0, 0);   // mflo held while busy
        step(32'h00002012, 0, 0, 0);   // unit free: hazard low, mflo enters

        step(32'h0043001A, 0, 0, 0);   // div
        repeat (3) step(32'h00000000, 0, 0, 0);
        step(32'h00002010, 0, 0, 1);   // reset during busy cycle 4
        step(32'h00002010, 0, 0, 0);

        step(32'h0C000010, 0, 1, 0);   // jal flushed
        step(32'h0C000010, 0, 0, 0);   // jal
        step(32'hFC000000, 0, 0, 0);   // unknown opcode 0x3F

        for (int f = 0; f < 64; f++) step({6'd0, 20'($urandom()), 6'(f)}, 0, 0, 0);
        for (int o = 1; o < 64; o++) step({6'(o), 26'($urandom())}, 0, 0, 0);
        step(32'h04110000, 0, 0, 0);   // bgezal
        step(32'h04100000, 0, 0, 0);   // bltzal
        step(32'h04010000, 0, 0, 0);   // bgez: no link

        for (int i = 0; i < 800; i++)
            step(rand_instr(), ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 49) == 0));

        step(32'h0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got=%0d pending expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
